// File: rtl/prog_loader_ctrl_pkg.sv
// Shared types and constants for the program loader controller.
package prog_loader_ctrl_pkg;

  localparam int unsigned DEF_DEPTH      = 256;
  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_ADD_WIDTH  = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned PACK_WIDTH     = 8 * BYTES_PER_WORD;
  localparam int unsigned LOW_WIDTH      = PACK_WIDTH - 8;

  localparam logic [6:0] HALT_OPCODE = 7'b1111111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSEMBLE = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RUN      = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  typedef struct packed {
    logic byte_ready;
    logic busy;
    logic mem_we;
    logic cpu_run;
    logic halted;
  } flags_t;

  // Output flags that belong to a state; loaded together with the state register.
  function automatic flags_t state_flags(input state_t s);
    flags_t f;
    f = '0;
    case (s)
      ST_ASSEMBLE: begin
        f.byte_ready = 1'b1;
        f.busy       = 1'b1;
      end
      ST_WRITE: begin
        f.busy   = 1'b1;
        f.mem_we = 1'b1;
      end
      ST_RUN:  f.cpu_run = 1'b1;
      ST_HALT: f.halted  = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/prog_loader_ctrl_byte_packer.sv
// Little-endian byte-to-word packer: first byte lands in [7:0], fourth in [31:24].
module byte_packer
  import prog_loader_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte_data,
  output logic [PACK_WIDTH-1:0] o_word_c,
  output logic                  o_word_valid_c
);

  logic [1:0]           r_idx;
  logic [LOW_WIDTH-1:0] r_low;

  // The 4th byte completes the word in the same cycle it is accepted.
  assign o_word_valid_c = i_byte_valid && (r_idx == 2'd3);
  assign o_word_c       = {i_byte_data, r_low};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_low <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_low <= '0;
    end else if (i_byte_valid) begin
      case (r_idx)
        2'd0:    r_low[7:0]   <= i_byte_data;
        2'd1:    r_low[15:8]  <= i_byte_data;
        2'd2:    r_low[23:16] <= i_byte_data;
        default: ;
      endcase
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader_ctrl.sv
// Loads a byte stream into program memory, then runs the CPU until a halt opcode is fetched.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum over all loaded words.
module prog_loader_ctrl
  import prog_loader_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ADD_WIDTH = DEF_ADD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic [ADD_WIDTH:0]   load_len,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 mem_we,
  output logic [ADD_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [ADD_WIDTH-1:0] cpu_pc,
  input  logic                 cpu_fetch,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [WIDTH-1:0]     checksum
);

  localparam int unsigned          LEN_W     = ADD_WIDTH + 1;
  localparam logic [LEN_W-1:0]     MAX_LEN   = LEN_W'(DEPTH);
  localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);

  state_t                 r_state;
  flags_t                 r_flags;
  logic                   r_err;
  logic [ADD_WIDTH-1:0]   r_wptr;
  logic [LEN_W-1:0]       r_count;
  logic [LEN_W-1:0]       r_len;
  logic [WIDTH-1:0]       r_mem_wdata;

  logic                   w_idle_like;
  logic                   w_len_legal;
  logic                   w_load_ok;
  logic                   w_byte_acc;
  logic                   w_halt_fetch;
  logic                   w_word_valid;
  logic [PACK_WIDTH-1:0]  w_word;
  logic [LEN_W-1:0]       w_count_inc;
  logic                   w_unused_rdata;

  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_HALT);
  assign w_len_legal  = (load_len != '0) && (load_len <= MAX_LEN);
  assign w_load_ok    = load_start && w_len_legal && w_idle_like;
  assign w_byte_acc   = byte_valid && r_flags.byte_ready;
  assign w_halt_fetch = cpu_fetch && (mem_rdata[6:0] == HALT_OPCODE);
  assign w_count_inc  = r_count + LEN_W'(1);
  assign w_unused_rdata = ^mem_rdata[WIDTH-1:7];

  byte_packer u_packer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clear        (w_load_ok),
    .i_byte_valid   (w_byte_acc),
    .i_byte_data    (byte_data),
    .o_word_c       (w_word),
    .o_word_valid_c (w_word_valid)
  );

  // Control FSM; flags are reloaded only on a state change so they always match r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_flags     <= '0;
      r_err       <= 1'b0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (load_start) begin
            if (w_len_legal) begin
              r_state <= ST_ASSEMBLE;
              r_flags <= state_flags(ST_ASSEMBLE);
              r_err   <= 1'b0;
              r_wptr  <= '0;
              r_count <= '0;
              r_len   <= load_len;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_ASSEMBLE: begin
          if (w_word_valid) begin
            r_state     <= ST_WRITE;
            r_flags     <= state_flags(ST_WRITE);
            r_mem_wdata <= WIDTH'(w_word);
          end
        end
        ST_WRITE: begin
          r_wptr  <= (r_wptr == LAST_ADDR) ? '0 : r_wptr + ADD_WIDTH'(1);
          r_count <= w_count_inc;
          if (w_count_inc == r_len) begin
            r_state <= ST_RUN;
            r_flags <= state_flags(ST_RUN);
          end else begin
            r_state <= ST_ASSEMBLE;
            r_flags <= state_flags(ST_ASSEMBLE);
          end
        end
        ST_RUN: begin
          if (w_halt_fetch) begin
            r_state <= ST_HALT;
            r_flags <= state_flags(ST_HALT);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_flags <= state_flags(ST_IDLE);
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;

  // Accumulates during the WRITE cycle, restarts with every legal load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_load_ok) begin
      r_checksum <= '0;
    end else if (r_flags.mem_we) begin
      r_checksum <= r_checksum ^ r_mem_wdata;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign byte_ready = r_flags.byte_ready;
  assign mem_we     = r_flags.mem_we;
  assign cpu_run    = r_flags.cpu_run;
  assign busy       = r_flags.busy;
  assign halted     = r_flags.halted;
  assign err        = r_err;
  assign mem_wdata  = r_mem_wdata;
  // Memory port belongs to the loader while busy, to the CPU otherwise.
  assign mem_addr   = r_flags.busy ? r_wptr : cpu_pc;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl: start-pulse vector table, directed loads and randomized loads.
module tb_prog_loader_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 8;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;
  typedef struct {
    int   len;
    logic exp_err;
    logic exp_busy;
  } start_vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_start;
  logic [AW:0]      load_len;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [AW-1:0]    cpu_pc;
  logic             cpu_fetch;
  logic [WIDTH-1:0] mem_rdata;
  logic             cpu_run;
  logic             busy;
  logic             halted;
  logic             err;
  logic [WIDTH-1:0] checksum;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  wr_t got_q[$];
  logic [WIDTH-1:0] shadow [DEPTH];

  prog_loader_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADD_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_pc(cpu_pc), .cpu_fetch(cpu_fetch), .mem_rdata(mem_rdata),
    .cpu_run(cpu_run), .busy(busy), .halted(halted), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // External program memory: captures every write strobe.
  always @(negedge clk) begin
    if (mem_we) begin
      got_q.push_back('{addr: mem_addr, data: mem_wdata});
      shadow[mem_addr] = mem_wdata;
      we_count++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge clk);
    rst_n = 1'b0; load_start = 1'b0; byte_valid = 1'b0; cpu_fetch = 1'b0;
    @(negedge clk);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_mem_we"},     mem_we,     0);
    check({tag, "_cpu_run"},    cpu_run,    0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_halted"},     halted,     0);
    check({tag, "_err"},        err,        0);
    check({tag, "_mem_wdata"},  mem_wdata,  0);
    check({tag, "_checksum"},   checksum,   0);
    check({tag, "_mem_addr"},   mem_addr,   cpu_pc);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 9'(len);
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // mode 0: no gaps, 1: valid toggles 1,0,1,0, 2: random gaps.
  task automatic send_bytes(input byte_q_t bq, input int mode, input bit noise);
    int i;
    int guard;
    bit v;
    bit acc;
    i = 0;
    guard = 0;
    while (i < bq.size()) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_data  = v ? bq[i] : 8'($urandom);
      if (noise) begin
        load_start = 1'($urandom_range(0, 1));
        load_len   = 9'($urandom);
      end
      acc = v && byte_ready;
      @(negedge clk);
      if (acc) i++;
      guard++;
      if (guard > 20000) begin
        check("send_timeout", 64'(i), 64'(bq.size()));
        break;
      end
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!cpu_run && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("run_reached", cpu_run, 1);
  endtask

  // Reference: word k is bytes 4k..4k+3 little-endian, stored at address k mod DEPTH.
  task automatic verify_writes(input string tag, input byte_q_t bq, input int len,
                               output logic [WIDTH-1:0] xs);
    logic [WIDTH-1:0] w;
    xs = '0;
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(len));
    for (int k = 0; k < len && k < got_q.size(); k++) begin
      w = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
      check({tag, "_addr"}, got_q[k].addr, 64'(k % DEPTH));
      check({tag, "_data"}, got_q[k].data, w);
      xs ^= w;
    end
  endtask

  task automatic do_load(input string tag, input byte_q_t bq, input int mode, input bit noise);
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] exp_ck;
    int len;
    len = bq.size() / 4;
    got_q.delete();
    pulse_start(len);
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_ready_start"}, byte_ready, 1);
    check({tag, "_halted_clr"}, halted, 0);
    check({tag, "_err_clr"}, err, 0);
    check({tag, "_ck_clr"}, checksum, 0);
    send_bytes(bq, mode, noise);
    wait_run();
    verify_writes(tag, bq, len, xs);
`ifdef LOADER_CHECKSUM_EN
    exp_ck = xs;
`else
    exp_ck = '0;
`endif
    check({tag, "_checksum"}, checksum, exp_ck);
    check({tag, "_busy_run"}, busy, 0);
    check({tag, "_err_run"}, err, 0);
  endtask

  task automatic do_halt(input string tag);
    @(negedge clk);
    cpu_pc    = 8'($urandom);
    cpu_fetch = 1'b1;
    mem_rdata = {25'($urandom), 7'h13};
    #1;
    check({tag, "_pc_addr"}, mem_addr, cpu_pc);
    @(negedge clk);
    check({tag, "_still_run"}, cpu_run, 1);
    cpu_fetch = 1'b0;
    mem_rdata = 32'h0000007F;
    @(negedge clk);
    check({tag, "_nofetch_run"}, cpu_run, 1);
    cpu_fetch = 1'b1;
    @(negedge clk);
    cpu_fetch = 1'b0;
    mem_rdata = '0;
    check({tag, "_halted"}, halted, 1);
    check({tag, "_run_off"}, cpu_run, 0);
    #1;
    check({tag, "_halt_addr"}, mem_addr, cpu_pc);
  endtask

  initial begin
    start_vec_t vecs[7];
    logic [7:0] req26 [8];
    logic [7:0] req31 [8];
    byte_q_t bq;
    int we_snap;

    vecs[0] = '{len: 0,   exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{len: 257, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{len: 511, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{len: 1,   exp_err: 1'b0, exp_busy: 1'b1};
    vecs[4] = '{len: 300, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[5] = '{len: 256, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[6] = '{len: 0,   exp_err: 1'b1, exp_busy: 1'b0};
    req26 = '{8'h13, 8'h05, 8'h80, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    req31 = '{8'h55, 8'h55, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'hFF, 8'hFF};

    rst_n = 1'b0; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
    cpu_pc = '0; cpu_fetch = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset_and_check("reset");

    // Start-pulse table from IDLE; a legal start is abandoned by reset.
    for (int i = 0; i < 7; i++) begin
      we_snap = we_count;
      pulse_start(vecs[i].len);
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_ready", i), byte_ready, vecs[i].exp_busy);
      check($sformatf("vec%0d_run", i), cpu_run, 0);
      check($sformatf("vec%0d_nowe", i), 64'(we_count), 64'(we_snap));
      if (vecs[i].exp_busy) reset_and_check($sformatf("vec%0d_rst", i));
    end
    reset_and_check("pre_directed");

    // Two-word load without gaps.
    bq.delete();
    foreach (req26[i]) bq.push_back(req26[i]);
    do_load("req26", bq, 0, 1'b0);
    check("req26_w0", shadow[0], 32'h00800513);
    check("req26_w1", shadow[1], 32'h00200113);

    // load_start is ignored while running.
    pulse_start(0);
    check("run_ign_err", err, 0);
    check("run_ign_run", cpu_run, 1);
    pulse_start(1);
    check("run_ign_busy", busy, 0);
    do_halt("halt1");

    // Same program with byte_valid toggling; a legal load also clears halted.
    shadow[0] = '0;
    shadow[1] = '0;
    do_load("req27", bq, 1, 1'b0);
    check("req27_w0", shadow[0], 32'h00800513);
    check("req27_w1", shadow[1], 32'h00200113);
    do_halt("halt2");

    // Illegal length from HALT: err set, still halted, memory untouched.
    we_snap = we_count;
    pulse_start(0);
    check("halt_bad_err", err, 1);
    check("halt_bad_halted", halted, 1);
    check("halt_bad_busy", busy, 0);
    check("halt_bad_nowe", 64'(we_count), 64'(we_snap));

    // Checksum words 0xAAAA5555 and 0xFFFF0000.
    bq.delete();
    foreach (req31[i]) bq.push_back(req31[i]);
    do_load("req31", bq, 0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("req31_ck_const", checksum, 32'h55555555);
`else
    check("req31_ck_const", checksum, 32'h0);
`endif
    do_halt("halt3");

    // Randomized loads with random gaps and ignored load_start noise.
    for (int r = 0; r < 6; r++) begin
      bq.delete();
      repeat (4 * $urandom_range(1, 6)) bq.push_back(8'($urandom));
      do_load($sformatf("rnd%0d", r), bq, 2, 1'b1);
      do_halt($sformatf("rhalt%0d", r));
    end

    // Full-depth load exercises the last address before the pointer wraps.
    bq.delete();
    repeat (4 * DEPTH) bq.push_back(8'($urandom));
    do_load("full", bq, 0, 1'b0);
    do_halt("halt_full");

    // Reset after 6 of 8 bytes: first word kept, load abandoned.
    shadow[0] = '0;
    bq.delete();
    foreach (req26[i]) bq.push_back(req26[i]);
    bq = bq[0:5];
    got_q.delete();
    pulse_start(2);
    send_bytes(bq, 0, 1'b0);
    check("req30_busy_mid", busy, 1);
    we_snap = we_count;
    reset_and_check("req30");
    check("req30_addr0", shadow[0], 32'h00800513);
    repeat (3) @(negedge clk);
    check("req30_idle_busy", busy, 0);
    check("req30_nowe", 64'(we_count), 64'(we_snap));

    // Packer must restart cleanly after the abandoned partial word.
    bq.delete();
    bq.push_back(8'hEF); bq.push_back(8'hBE); bq.push_back(8'hAD); bq.push_back(8'hDE);
    do_load("post_rst", bq, 2, 1'b0);
    check("post_rst_w0", shadow[0], 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader_ctrl.md
PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 SHALL have parameters: DEPTH, default 256, number of program-memory words; WIDTH, default 32, instruction width; ADD_WIDTH, default 8, address width.
REQ-002 SHALL have these ports, named and typed as listed:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- load_start  input  1  one-cycle pulse that begins a load.
- load_len  input  ADD_WIDTH+1  number of words to load, valid range 1..DEPTH.
- byte_valid  input  1  an incoming program byte is present.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  the block accepts a byte this cycle.
- mem_we  output  1  program-memory write strobe.
- mem_addr  output  ADD_WIDTH  program-memory address.
- mem_wdata  output  WIDTH  program-memory write data.
- cpu_pc  input  ADD_WIDTH  CPU fetch address.
- cpu_fetch  input  1  CPU fetch this cycle.
- mem_rdata  input  WIDTH  asynchronous-read instruction.
- cpu_run  output  1  CPU enable.
- busy  output  1  a load is in progress.
- halted  output  1  the CPU has fetched a halt instruction.
- err  output  1  sticky error for an illegal load_len.
- checksum  output  WIDTH  XOR of all loaded words.

Function
REQ-003 SHALL implement the states IDLE, ASSEMBLE, WRITE, RUN and HALT.
REQ-004 IDLE: on load_start with load_len in 1..DEPTH, SHALL clear the word counter and write pointer and go to ASSEMBLE next cycle.
REQ-005 IDLE: on load_start with load_len equal to 0 or greater than DEPTH, SHALL set err, stay in IDLE and leave memory untouched.
REQ-006 ASSEMBLE: byte_ready SHALL be 1; a byte is accepted only when byte_valid and byte_ready are both 1.
REQ-007 Bytes SHALL pack little-endian: the first accepted byte goes to bits [7:0], the fourth to [31:24].
REQ-008 After the 4th accepted byte SHALL go to WRITE; byte_ready SHALL be 0 in WRITE.
REQ-009 WRITE lasts exactly one cycle, with mem_we=1, mem_addr=write pointer, mem_wdata=assembled word.
REQ-010 After WRITE the pointer and count SHALL increment; if count equals load_len go to RUN, otherwise go to ASSEMBLE.
REQ-011 A write pointer at DEPTH-1 SHALL wrap to 0 with no fault; this is reachable only when load_len=DEPTH.
REQ-012 busy SHALL be 1 in ASSEMBLE and WRITE only.
REQ-013 RUN: cpu_run SHALL be 1 and mem_addr SHALL equal cpu_pc.
REQ-014 mem_addr SHALL equal cpu_pc in every state except ASSEMBLE and WRITE, where it SHALL equal the write pointer.
REQ-015 RUN: when cpu_fetch=1 and mem_rdata[6:0]=7'b1111111, SHALL go to HALT next cycle, with cpu_run=0 and halted=1 from that cycle on.
REQ-016 load_start SHALL be ignored in ASSEMBLE, WRITE and RUN.
REQ-017 HALT: load_start SHALL behave as in IDLE; a legal load clears halted.
REQ-018 A legal load_start SHALL clear err.
REQ-019 mem_we SHALL never be 1 outside WRITE.
REQ-020 byte_valid SHALL be ignored outside ASSEMBLE.

Reset
REQ-021 While rst_n=0 at a clock edge, SHALL enter IDLE with byte_ready, mem_we, cpu_run, busy, halted and err at 0, mem_wdata and checksum at 0, and counters and the partial word cleared.
REQ-022 Reset asserted mid-load SHALL abandon the load; words already written stay in memory.

Configuration
REQ-023 With LOADER_CHECKSUM_EN defined, checksum SHALL XOR-accumulate each word in its WRITE cycle and clear on a legal load_start; without the macro, checksum SHALL be constant 0 and the accumulator SHALL not exist.

Structure
REQ-024 A shared package SHALL hold the state enum, HALT_OPCODE (7'b1111111) and the default width constants.
REQ-025 Byte packing SHALL live in one sub-module, byte_packer (byte in, word plus word_valid out).

Verification
REQ-026 Load 2 words (bytes 13,05,80,00,13,01,20,00) -> writes 0x00800513 at addr 0 and 0x00200113 at addr 1, then cpu_run=1.
REQ-027 Apply byte_valid toggling 1,0,1,0 during a load -> only handshaken bytes are packed, and the same words are written as with no gaps.
REQ-028 In RUN, drive mem_rdata=0x0000007F with cpu_fetch=1 -> halted=1 and cpu_run=0 on the next cycle; a new legal load clears halted.
REQ-029 Pulse load_start with load_len=0 -> err=1, state stays IDLE, and no mem_we is seen.
REQ-030 Assert rst_n=0 after 6 of 8 bytes -> IDLE with all outputs 0, and addr 0 holds the first word.
REQ-031 With LOADER_CHECKSUM_EN defined, load 0xAAAA5555 then 0xFFFF0000 -> checksum=0x55555555; without the macro -> checksum=0.
